// File: rtl/uart_rcv.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rcv
//  Brief    : 8N1 asynchronous serial receiver (LSB first, idle-high line).
//             Two-flop input synchronizer, mid-bit sampling, byte presented
//             on rx_data and flagged with rdy.
//             Optional stop-bit checking: define UART_RCV_FRM_ERR_EN.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rcv #(
    parameter int BAUD_CNT = 2604,  // clocks per bit
    parameter int HALF_CNT = 1302   // clocks from start detection to start-bit center
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

    // The cycle on which the counter sits at zero is itself one clock of the
    // bit period, so the reload is one less than the period.
    localparam logic [11:0] C_HALF     = 12'(HALF_CNT);
    localparam logic [11:0] C_BAUD_M1  = 12'(BAUD_CNT - 1);
    localparam logic [3:0]  C_LAST_BIT = 4'd9;

    state_t      state_q;
    logic        rx_meta_q;
    logic        rx_s_q;
    logic [11:0] baud_cnt_q;
    logic [3:0]  bit_cnt_q;
    logic [8:0]  shft_q;
    logic        rdy_q;

    logic [8:0]  shft_d;
    logic        w_start;
    logic        w_tick;
    logic        w_done;
    logic        w_stop_ok;

    assign shft_d  = {rx_s_q, shft_q[8:1]};
    assign w_start = (state_q == IDLE) && !rx_s_q;
    assign w_tick  = (state_q == RECEIVE) && (baud_cnt_q == 12'd0);
    assign w_done  = w_tick && (bit_cnt_q == C_LAST_BIT);

`ifdef UART_RCV_FRM_ERR_EN
    // The stop bit is the value being shifted in on the completion tick.
    assign w_stop_ok = rx_s_q;
`else
    assign w_stop_ok = 1'b1;
`endif

    // Two-flop synchronizer; resets to idle-high so reset release never looks like a start bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receive FSM with bit timing, shift register and the rdy flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= 12'd0;
            bit_cnt_q  <= 4'd0;
            shft_q     <= 9'd0;
            rdy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q    <= RECEIVE;
                        baud_cnt_q <= C_HALF;
                        bit_cnt_q  <= 4'd0;
                    end
                end
                RECEIVE: begin
                    if (baud_cnt_q == 12'd0) begin
                        if ((bit_cnt_q == 4'd0) && rx_s_q) begin
                            // Start bit no longer low at its center: a glitch.
                            state_q <= IDLE;
                        end else begin
                            shft_q     <= shft_d;
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                            baud_cnt_q <= C_BAUD_M1;
                            if (bit_cnt_q == C_LAST_BIT) begin
                                state_q <= IDLE;
                            end
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 12'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Setting on completion takes priority over any clear on the same cycle.
            if (w_done && w_stop_ok) begin
                rdy_q <= 1'b1;
            end else if (w_start || clr_rdy) begin
                rdy_q <= 1'b0;
            end
        end
    end

`ifdef UART_RCV_FRM_ERR_EN
    logic frm_err_q;

    // Framing-error flag: raised by a low stop bit, cleared like rdy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frm_err_q <= 1'b0;
        end else if (w_done && !rx_s_q) begin
            frm_err_q <= 1'b1;
        end else if (w_start || clr_rdy) begin
            frm_err_q <= 1'b0;
        end
    end

    assign frm_err = frm_err_q;
`else
    assign frm_err = 1'b0;
`endif

    assign rx_data = shft_q[7:0];
    assign rdy     = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rcv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rcv
//  Brief    : Directed self-checking bench for uart_rcv (scaled baud timing).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rcv;

    localparam int BAUD  = 32;
    localparam int HALF  = 16;
    localparam int FRAME = 10 * BAUD;
    // RX fall -> rdy window, measured in clocks: HALF + 9*BAUD + 1 plus 1..4
    localparam int WIN_LO = HALF + 9 * BAUD + 2;
    localparam int WIN_HI = HALF + 9 * BAUD + 5;

    logic       clk;
    logic       rst_n;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    int vecs;
    int errs;

    int         rise_cyc;
    logic [7:0] rise_dat;
    int         drop_cyc;
    int         ferr_cyc;
    int         hi_cnt;

    uart_rcv #(
        .BAUD_CNT (BAUD),
        .HALF_CNT (HALF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        vecs++;
        assert ((obs >= lo) && (obs <= hi))
        else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Transmit one frame. Negedge n=0 drives the start bit; each later negedge
    // first samples the DUT (reflecting posedge n) and then drives the line.
    task automatic send(input logic [7:0] d, input logic stop, input int clr_at,
                        input int abort_at, output int r_cyc, output logic [7:0] r_dat,
                        output int d_cyc, output int f_cyc);
        logic [9:0] bits;
        logic       seen_low;
        bits     = {stop, d, 1'b0};
        seen_low = 1'b0;
        r_cyc    = -1;
        r_dat    = 8'h00;
        d_cyc    = -1;
        f_cyc    = -1;
        for (int n = 0; n < FRAME; n++) begin
            @(negedge clk);
            if (!rdy) begin
                seen_low = 1'b1;
                if (d_cyc < 0) d_cyc = n;
            end else if (seen_low && (r_cyc < 0)) begin
                r_cyc = n;
                r_dat = rx_data;
            end
            if (frm_err && (f_cyc < 0)) f_cyc = n;
            if (n == abort_at) begin
                rst_n   = 1'b0;
                RX      = 1'b1;
                clr_rdy = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            RX      = bits[n / BAUD];
            clr_rdy = (n == clr_at);
        end
        clr_rdy = 1'b0;
    endtask

    task automatic idle_count(input int cycles, output int highs);
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rdy) highs++;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    initial begin
        vecs    = 0;
        errs    = 0;
        rst_n   = 1'b0;
        RX      = 1'b1;
        clr_rdy = 1'b0;

        // Reset state
        repeat (4) @(negedge clk);
        chk("reset_rdy", 32'(rdy), 32'd0);
        chk("reset_frm_err", 32'(frm_err), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        rst_n = 1'b1;

        // Basic receive of 'g' after an idle period
        idle_count(100, hi_cnt);
        send(8'h67, 1'b1, -1, -1, rise_cyc, rise_dat, drop_cyc, ferr_cyc);
        chk_rng("basic_latency", rise_cyc, WIN_LO, WIN_HI);
        chk("basic_data", 32'(rise_dat), 32'h67);
        chk("basic_rdy_held", 32'(rdy), 32'd1);
        pulse_clr();
        chk("basic_clr", 32'(rdy), 32'd0);

        // Back-to-back frames with no acknowledge
        send(8'hA5, 1'b1, -1, -1, rise_cyc, rise_dat, drop_cyc, ferr_cyc);
        chk_rng("b2b_first_latency", rise_cyc, WIN_LO, WIN_HI);
        chk("b2b_first_data", 32'(rise_dat), 32'hA5);
        send(8'h5A, 1'b1, -1, -1, rise_cyc, rise_dat, drop_cyc, ferr_cyc);
        chk_rng("b2b_rdy_drop", drop_cyc, 1, 3);
        chk_rng("b2b_second_latency", rise_cyc, WIN_LO, WIN_HI);
        chk("b2b_second_data", 32'(rise_dat), 32'h5A);

        // Glitch rejection: low pulse well under half a bit
        pulse_clr();
        @(negedge clk);
        RX = 1'b0;
        repeat (8) @(negedge clk);
        RX = 1'b1;
        idle_count(3 * BAUD, hi_cnt);
        chk("glitch_no_rdy", 32'(hi_cnt), 32'd0);
        send(8'h3C, 1'b1, -1, -1, rise_cyc, rise_dat, drop_cyc, ferr_cyc);
        chk_rng("glitch_next_latency", rise_cyc, WIN_LO, WIN_HI);
        chk("glitch_next_data", 32'(rise_dat), 32'h3C);

        // Set beats clear: clr_rdy high on the completion edge
        pulse_clr();
        send(8'hFF, 1'b1, WIN_LO + 1, -1, rise_cyc, rise_dat, drop_cyc, ferr_cyc);
        chk("setclr_data", 32'(rise_dat), 32'hFF);
        chk_rng("setclr_latency", rise_cyc, WIN_LO, WIN_HI);
        chk("setclr_rdy_held", 32'(rdy), 32'd1);

        // Reset during d4 of 0x81, line then idles high
        send(8'h81, 1'b1, -1, 5 * BAUD + 10, rise_cyc, rise_dat, drop_cyc, ferr_cyc);
        @(negedge clk);
        chk("rstmid_rdy", 32'(rdy), 32'd0);
        chk("rstmid_rx_data", 32'(rx_data), 32'h00);
        idle_count(FRAME + BAUD, hi_cnt);
        chk("rstmid_no_rdy", 32'(hi_cnt), 32'd0);
        send(8'h00, 1'b1, -1, -1, rise_cyc, rise_dat, drop_cyc, ferr_cyc);
        chk_rng("rstmid_next_latency", rise_cyc, WIN_LO, WIN_HI);
        chk("rstmid_next_data", 32'(rise_dat), 32'h00);

        // Bad stop bit on 0x55
        pulse_clr();
        send(8'h55, 1'b0, -1, -1, rise_cyc, rise_dat, drop_cyc, ferr_cyc);
`ifdef UART_RCV_FRM_ERR_EN
        chk("badstop_no_rdy", 32'(rise_cyc), 32'hFFFF_FFFF);
        chk_rng("badstop_frm_err", ferr_cyc, WIN_LO, WIN_HI);
        chk("badstop_rx_data", 32'(rx_data), 32'h55);
`else
        chk_rng("badstop_latency", rise_cyc, WIN_LO, WIN_HI);
        chk("badstop_data", 32'(rise_dat), 32'h55);
        chk("badstop_frm_err", 32'(ferr_cyc), 32'hFFFF_FFFF);
`endif
        RX = 1'b1;
        idle_count(2 * BAUD, hi_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rcv.md
# uart_rcv

Asynchronous serial receiver (8N1, LSB first, idle-high line) for the Segway's `RX` input from the BLE module. It is the receive-side counterpart of `UART_tx`. It recovers each byte by mid-bit sampling, presents it on `rx_data` and flags it with `rdy`. It feeds the authorization block that waits for `'g'` (0x67) and `'s'` commands.

## Interface
Parameters:
- `BAUD_CNT`, default 2604: clocks per bit (50 MHz / 19200 baud).
- `HALF_CNT`, default 1302: clocks from start-edge detection to mid-start-bit sample.

Ports:
- `clk`  in  1  system clock, posedge.
- `rst_n`  in  1  synchronous active-low reset, sampled on posedge `clk`.
- `RX`  in  1  asynchronous serial line, idle high.
- `clr_rdy`  in  1  consumer acknowledge; clears `rdy`.
- `rx_data`  out  8  received byte; valid while `rdy`=1.
- `rdy`  out  1  byte available.
- `frm_err`  out  1  stop-bit error flag. Tied 0 when the macro in Configuration is absent.

## Operation
- **Synchronizer.** `RX` passes through 2 flops. Both flops reset to 1, so leaving reset never produces a false start. All logic uses the synchronized `rx_s`.
- **Datapath.**
  - `baud_cnt`: 12-bit down-counter.
  - `bit_cnt`: 4-bit counter of shifts.
  - `shft`: 9-bit shift register. It shifts right with `rx_s` entering bit 8.
- **States:** IDLE and RECEIVE.
- **IDLE:**
  - `rx_s`=0 triggers start. On the same edge: go to RECEIVE, load `baud_cnt`=`HALF_CNT`, set `bit_cnt`=0, clear `rdy` (and `frm_err`).
- **RECEIVE:**
  - `baud_cnt` decrements every clock.
  - When `baud_cnt`==0: shift, increment `bit_cnt`, reload `BAUD_CNT`.
  - **False start.** Check the first shift (`bit_cnt`==0). If `rx_s` is 1 there, the start bit was a glitch: return to IDLE. Nothing else changes; `rdy` stays 0.
  - **Completion.** After the 10th shift (`bit_cnt` reaches 10):
    - `shft[7:0]` holds d7..d0 and `shft[8]` holds the stop bit.
    - Go to IDLE and set `rdy`=1.
- **`rx_data`:** driven as `shft[7:0]`. It is only guaranteed stable while `rdy`=1.
- **`rdy` set and clear:**
  - Set on completion.
  - Cleared by `clr_rdy`=1 or by the next start detection.
  - If set and clear land on the same cycle, set wins.
  - `clr_rdy` has no effect on reception.
- **Reset values:**
  - `rdy`=0, `frm_err`=0, `rx_data`=0x00 (`shft`=0).
  - State IDLE, counters 0, sync flops 1.
- **Reset mid-frame:** the frame is discarded, the block returns to IDLE with the reset values above, and `rdy` does not assert.

## Timing
- Sampling points:
  - Start bit at `HALF_CNT` clocks after detection.
  - Each following bit (d0..d7, stop) `BAUD_CNT` clocks later. Samples land at bit centers.
- Latency:
  - RX falling edge to start detection: 2–3 clocks (synchronizer).
  - Detection to `rdy`=1: `HALF_CNT` + 9·`BAUD_CNT` + 1 = 24,739 clocks at defaults.
  - Bench window from RX pin falling edge: 24,740–24,743 clocks.
- Back-to-back frames:
  - The next start bit may begin immediately after the stop-bit center.
  - IDLE accepts a start on the cycle after completion.
  - `rdy` clears on that detection. The consumer must take `rx_data` within about half a bit time after the stop-bit center.
- Tolerates ±2% baud mismatch (sampling stays within the middle of each bit across 10 bits).

## Configuration
- Macro: `UART_RCV_FRM_ERR_EN`.
- Defined:
  - At completion, if `shft[8]`==0: `rdy` stays 0, `frm_err`=1.
  - `rx_data` still reflects the shifted byte.
  - `frm_err` holds until `clr_rdy`, the next start detection, or reset.
  - A valid stop bit gives `rdy`=1 and `frm_err`=0.
- Undefined:
  - The stop bit is ignored and `rdy` asserts on every completed frame.
  - `frm_err` is constant 0.
  - The port remains present.

## Test plan
- **Basic receive:** `UART_tx` sends 0x67 after 50,000 idle clocks. Required: `rdy` rises inside the latency window, `rx_data`=0x67. Pulsing `clr_rdy` for 1 clock then gives `rdy`=0.
- **Back-to-back, no acknowledge:** send 0xA5 then 0x5A with no `clr_rdy`. Required:
  - `rdy`=1 with 0xA5.
  - `rdy` drops within 3 clocks of the second start.
  - `rdy`=1 with 0x5A.
- **Glitch rejection:** drive `RX` low for 500 clocks, then high. Required: no `rdy`, state returns to IDLE, and a following 0x3C is received correctly.
- **Set beats clear:** assert `clr_rdy` on the completion cycle of 0xFF. Required: `rdy`=1, `rx_data`=0xFF.
- **Reset mid-frame:** assert `rst_n`=0 for 1 clock during d4 of 0x81. Required:
  - `rdy`=0, `rx_data`=0x00.
  - No `rdy` from the remainder of that frame; the only trigger is a stray start bit when RX is low, so the bench idles RX high before resending.
  - The next 0x00 frame receives as 0x00 with `rdy`=1.
- **Bad stop bit:** hold stop bit low on 0x55.
  - With `UART_RCV_FRM_ERR_EN`: `frm_err`=1, `rdy`=0.
  - Without it: `rdy`=1, `rx_data`=0x55, `frm_err`=0.
